// File: rtl/timer_pkg.sv
// Purpose: shared types and defaults for the min:sec countdown control stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (controller states), CLK_DIV_DEF / ALARM_SECS_DEF defaults
//           that the digit-counter benches reuse.
package timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSE,
      ST_ALARM
   } state_t;

   localparam int CLK_DIV_DEF    = 100;  // clk cycles per 1 s tick, >= 2
   localparam int ALARM_SECS_DEF = 5;    // ticks the alarm stays up, >= 1

endpackage

// File: rtl/timer_ctrl_if.sv
// Purpose: request/strobe bundle between a host and timer_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; requests are levels sampled every cycle.
// Signals: start, pause, load_req, zero_in (host -> ctrl);
//          en_out, loadneg_out, clearneg_out, running, alarm (ctrl -> host/chain).
interface timer_ctrl_if;
   import timer_pkg::*;

   logic start;
   logic pause;
   logic load_req;
   logic zero_in;
   logic en_out;
   logic loadneg_out;
   logic clearneg_out;
   logic running;
   logic alarm;

   modport master (
      output start, pause, load_req, zero_in,
      input  en_out, loadneg_out, clearneg_out, running, alarm
   );

   modport slave (
      input  start, pause, load_req, zero_in,
      output en_out, loadneg_out, clearneg_out, running, alarm
   );

endinterface

// File: rtl/tick_gen.sv
// Purpose: 1 s prescaler, counts 0..CLK_DIV-1 while enabled and flags the wrap.
// Latency: wrap is combinational from the count; first wrap CLK_DIV enabled cycles after restart.
// Backpressure: none; run_en low simply freezes the count.
// Ports: clk, clear (sync reset), run_en (advance), restart (force to 0), wrap (out).
module tick_gen
   import timer_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic clear,
   input  logic run_en,
   input  logic restart,
   output logic wrap
);

   localparam int               DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] cnt;

   // restart wins over run_en so a state change can zero the count on the
   // same edge that would otherwise advance it.
   always_ff @(posedge clk) begin
      if (clear || restart) begin
         cnt <= '0;
      end else if (run_en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
      end
   end

   assign wrap = run_en && (cnt == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Purpose: start/pause/load/alarm sequencing and strobes for the min:sec digit chain.
// Latency: en_out/loadneg_out/clearneg_out combinational; state changes one edge after the request.
// Backpressure: none; requests are levels, an ignored request is simply dropped.
// Ports: clk, clear (sync active-high reset), bus (timer_ctrl_if.slave).
// Params: CLK_DIV (cycles per tick), ALARM_SECS (ticks of alarm before auto-return).
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_DEF,
   parameter int ALARM_SECS = ALARM_SECS_DEF
) (
   input  logic         clk,
   input  logic         clear,
   timer_ctrl_if.slave  bus
);

   localparam int                ACNT_W    = $clog2(ALARM_SECS + 1);
   localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);

   state_t              state;
   state_t              state_nxt;
   logic                run_en;
   logic                restart;
   logic                wrap;
   logic                alarm_done;
   logic [ACNT_W-1:0]   acnt;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .clear   (clear),
      .run_en  (run_en),
      .restart (restart),
      .wrap    (wrap)
   );

   assign alarm_done = wrap && (acnt == ACNT_LAST);

   always_ff @(posedge clk) begin
      if (clear) begin
         state <= ST_IDLE;
         acnt  <= '0;
      end else begin
         state <= state_nxt;
         // The wrap counter only lives while we stay in ALARM; any exit zeroes it.
         if ((state != ST_ALARM) || (state_nxt != ST_ALARM)) begin
            acnt <= '0;
         end else if (wrap) begin
            acnt <= acnt + ACNT_W'(1);
         end
      end
   end

   // pause only means something in RUN/PAUSE; elsewhere it is ignored rather
   // than masking start. load_req is ignored in RUN.
   always_comb begin
      state_nxt = state;
      run_en    = 1'b0;
      restart   = 1'b0;
      case (state)
         ST_IDLE: begin
            restart = 1'b1;
            if (bus.load_req) begin
               state_nxt = ST_LOAD;
            end else if (bus.start && !bus.zero_in) begin
               state_nxt = ST_RUN;
            end
         end
         ST_LOAD: begin
            restart   = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.zero_in) begin
               // Terminal count: no tick this cycle, alarm starts from a fresh second.
               restart   = 1'b1;
               state_nxt = ST_ALARM;
            end else begin
               // The pausing cycle still counts, so resume neither adds nor
               // drops a partial second.
               run_en = 1'b1;
               if (bus.pause) begin
                  state_nxt = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (bus.load_req) begin
               state_nxt = ST_LOAD;
            end else if (!bus.pause && bus.start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_ALARM: begin
            run_en = 1'b1;
            if (bus.start || bus.load_req || alarm_done) begin
               restart   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            restart   = 1'b1;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Strobes are gated by clear so nothing leaks on the cycle the chain is cleared.
   assign bus.en_out       = (state == ST_RUN) && wrap && !clear;
   assign bus.loadneg_out  = !((state == ST_LOAD) && !clear);
   assign bus.clearneg_out = ~clear;
   assign bus.running      = (state == ST_RUN);
   assign bus.alarm        = (state == ST_ALARM);

endmodule
